sb_link_tx: RTL and testbench

// Sideband link controller on the transmit side. It runs on sb_clk and is the counterpart of the timeout timer.
// - Drives sbtx low for the tDisconnectTx interval.
// - Then raises sbtx and qualifies the peer's connect level on sbrx.
// - Once connected, serializes bytes onto sbtx in start/data/stop frames.
// - Falls back to the disconnected state on a local request or when sbrx stays low too long.

---
 rtl/sb_link_tx_if.sv | 10 +
 rtl/sb_link_tx.sv | 180 ++++++++++++++++++
 tb/tb_sb_link_tx.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sb_link_tx_if.sv
// Byte-stream handshake into the sideband transmitter: data/valid from the
// producer, ready back from the link.
interface sb_link_tx_if;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;

   modport master (output tx_data, output tx_valid, input tx_ready);
   modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/sb_link_tx.sv
// Sideband link transmitter: disconnect/connect handshake on sbtx/sbrx plus a
// start/data/stop byte serializer. Define SB_PARITY_EN to add an even-parity bit.
module sb_link_tx #(
   parameter int TDISCONNECT_TX_CYC = 50,
   parameter int TCONNECT_RX_CYC    = 25,
   parameter int TDISCONNECT_RX_CYC = 14,
   parameter int CNT_W              = 8
) (
   input  logic          sb_clk,
   input  logic          rst,
   input  logic          enable,
   input  logic          disconnect_req,
   input  logic          sbrx,
   sb_link_tx_if.slave   tx,
   output logic          sbtx,
   output logic          disconnected_s,
   output logic          connected,
   output logic          tx_busy
);

   typedef enum logic [1:0] {
      ST_DISCONNECTED,
      ST_CONNECTING,
      ST_CONNECTED
   } state_t;

`ifdef SB_PARITY_EN
   localparam int FRAME_BITS = 11;
   logic [FRAME_BITS-2:0] payload;
   assign payload = {1'b1, ^tx.tx_data, tx.tx_data};
`else
   localparam int FRAME_BITS = 10;
   logic [FRAME_BITS-2:0] payload;
   assign payload = {1'b1, tx.tx_data};
`endif

   localparam logic [CNT_W-1:0] DIS_MAX  = CNT_W'(TDISCONNECT_TX_CYC - 1);
   localparam logic [CNT_W-1:0] HI_MAX   = CNT_W'(TCONNECT_RX_CYC - 1);
   localparam logic [CNT_W-1:0] LO_MAX   = CNT_W'(TDISCONNECT_RX_CYC - 1);
   localparam logic [3:0]       LAST_BIT = 4'(FRAME_BITS - 1);

   state_t                state_q, state_d;
   logic [CNT_W-1:0]      dis_cnt_q, dis_cnt_d;
   logic [CNT_W-1:0]      hi_cnt_q, hi_cnt_d;
   logic [CNT_W-1:0]      lo_cnt_q, lo_cnt_d;
   logic [3:0]            bit_cnt_q, bit_cnt_d;
   logic [FRAME_BITS-2:0] frame_q, frame_d;
   logic                  sbtx_q, sbtx_d;
   logic                  disc_q, disc_d;
   logic                  conn_q, conn_d;
   logic                  ready_q, ready_d;
   logic                  busy_q, busy_d;
   logic                  lo_hit;

   assign lo_hit = !sbrx && (lo_cnt_q == LO_MAX);

   always_comb begin
      state_d   = state_q;
      dis_cnt_d = dis_cnt_q;
      hi_cnt_d  = hi_cnt_q;
      lo_cnt_d  = lo_cnt_q;
      bit_cnt_d = bit_cnt_q;
      frame_d   = frame_q;
      // Outputs default to the disconnected values; each state overrides.
      sbtx_d    = 1'b0;
      disc_d    = 1'b1;
      conn_d    = 1'b0;
      ready_d   = 1'b0;
      busy_d    = 1'b0;

      case (state_q)
         ST_DISCONNECTED: begin
            if (dis_cnt_q != DIS_MAX) begin
               dis_cnt_d = dis_cnt_q + 1'b1;
            end
            if ((dis_cnt_q == DIS_MAX) && enable) begin
               state_d  = ST_CONNECTING;
               hi_cnt_d = '0;
               sbtx_d   = 1'b1;
               disc_d   = 1'b0;
            end
         end

         ST_CONNECTING: begin
            sbtx_d = 1'b1;
            disc_d = 1'b0;
            if (!enable || disconnect_req) begin
               state_d   = ST_DISCONNECTED;
               dis_cnt_d = '0;
               sbtx_d    = 1'b0;
               disc_d    = 1'b1;
            end else if (sbrx) begin
               if (hi_cnt_q == HI_MAX) begin
                  state_d  = ST_CONNECTED;
                  lo_cnt_d = '0;
                  conn_d   = 1'b1;
                  ready_d  = 1'b1;
               end else begin
                  hi_cnt_d = hi_cnt_q + 1'b1;
               end
            end else begin
               hi_cnt_d = '0;
            end
         end

         ST_CONNECTED: begin
            // A disconnect cause wins over a byte offered in the same cycle.
            if (!enable || disconnect_req || lo_hit) begin
               state_d   = ST_DISCONNECTED;
               dis_cnt_d = '0;
               bit_cnt_d = '0;
            end else begin
               disc_d   = 1'b0;
               conn_d   = 1'b1;
               lo_cnt_d = sbrx ? '0 : lo_cnt_q + 1'b1;
               if (busy_q) begin
                  if (bit_cnt_q == LAST_BIT) begin
                     bit_cnt_d = '0;
                     ready_d   = 1'b1;
                     sbtx_d    = 1'b1;
                  end else begin
                     busy_d    = 1'b1;
                     sbtx_d    = frame_q[0];
                     frame_d   = frame_q >> 1;
                     bit_cnt_d = bit_cnt_q + 4'd1;
                  end
               end else if (tx.tx_valid && ready_q) begin
                  busy_d    = 1'b1;
                  sbtx_d    = 1'b0;
                  frame_d   = payload;
                  bit_cnt_d = '0;
               end else begin
                  ready_d = 1'b1;
                  sbtx_d  = 1'b1;
               end
            end
         end

         default: begin
            state_d   = ST_DISCONNECTED;
            dis_cnt_d = '0;
         end
      endcase
   end

   always_ff @(posedge sb_clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_DISCONNECTED;
         dis_cnt_q <= '0;
         hi_cnt_q  <= '0;
         lo_cnt_q  <= '0;
         bit_cnt_q <= '0;
         frame_q   <= '0;
         sbtx_q    <= 1'b0;
         disc_q    <= 1'b1;
         conn_q    <= 1'b0;
         ready_q   <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         dis_cnt_q <= dis_cnt_d;
         hi_cnt_q  <= hi_cnt_d;
         lo_cnt_q  <= lo_cnt_d;
         bit_cnt_q <= bit_cnt_d;
         frame_q   <= frame_d;
         sbtx_q    <= sbtx_d;
         disc_q    <= disc_d;
         conn_q    <= conn_d;
         ready_q   <= ready_d;
         busy_q    <= busy_d;
      end
   end

   assign sbtx           = sbtx_q;
   assign disconnected_s = disc_q;
   assign connected      = conn_q;
   assign tx_busy        = busy_q;
   assign tx.tx_ready    = ready_q;

endmodule

// File: tb/tb_sb_link_tx.sv
// Self-checking bench for sb_link_tx: directed link scenarios followed by
// randomized traffic, all compared against a queue-based link model.
module tb_sb_link_tx;

   localparam int TDX = 50;
   localparam int TCR = 25;
   localparam int TDR = 14;
`ifdef SB_PARITY_EN
   localparam int FLEN = 11;
`else
   localparam int FLEN = 10;
`endif
   localparam int P_DISC = 0;
   localparam int P_CONN = 1;
   localparam int P_LINK = 2;

   logic sb_clk = 1'b0;
   logic rst;
   logic enable;
   logic disconnect_req;
   logic sbrx;
   logic sbtx;
   logic disconnected_s;
   logic connected;
   logic tx_busy;

   sb_link_tx_if tx_if ();

   sb_link_tx dut (
      .sb_clk         (sb_clk),
      .rst            (rst),
      .enable         (enable),
      .disconnect_req (disconnect_req),
      .sbrx           (sbrx),
      .tx             (tx_if),
      .sbtx           (sbtx),
      .disconnected_s (disconnected_s),
      .connected      (connected),
      .tx_busy        (tx_busy)
   );

   always #5 sb_clk = ~sb_clk;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: link phase, plain counters and the queue of line bits
   // still to be shown for the current frame (front = bit on sbtx now).
   int   m_phase;
   int   m_dis;
   int   m_run;
   int   m_lo;
   logic m_bits[$];

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [10:0] frame_vec(input logic [7:0] d);
      logic [10:0] v;
      v    = '1;
      v[0] = 1'b0;
      for (int i = 0; i < 8; i++) v[i+1] = d[i];
`ifdef SB_PARITY_EN
      v[9] = ^d;
`endif
      v[FLEN-1] = 1'b1;
      return v;
   endfunction

   task automatic model_reset();
      m_phase = P_DISC;
      m_dis   = 0;
      m_run   = 0;
      m_lo    = 0;
      m_bits.delete();
   endtask

   task automatic model_step();
      logic [10:0] v;
      if (!rst) begin
         model_reset();
         return;
      end
      case (m_phase)
         P_DISC: begin
            if (m_dis == TDX-1 && enable) begin
               m_phase = P_CONN;
               m_run   = 0;
            end else if (m_dis < TDX-1) begin
               m_dis++;
            end
         end
         P_CONN: begin
            if (!enable || disconnect_req) begin
               m_phase = P_DISC;
               m_dis   = 0;
            end else if (sbrx) begin
               if (m_run + 1 == TCR) begin
                  m_phase = P_LINK;
                  m_lo    = 0;
                  m_bits.delete();
               end else begin
                  m_run++;
               end
            end else begin
               m_run = 0;
            end
         end
         default: begin
            if (!enable || disconnect_req || (!sbrx && m_lo + 1 == TDR)) begin
               m_phase = P_DISC;
               m_dis   = 0;
               m_bits.delete();
            end else begin
               m_lo = sbrx ? 0 : m_lo + 1;
               if (m_bits.size() != 0) begin
                  void'(m_bits.pop_front());
               end else if (tx_if.tx_valid) begin
                  v = frame_vec(tx_if.tx_data);
                  for (int i = 0; i < FLEN; i++) m_bits.push_back(v[i]);
                  $display("tx byte %02h accepted t=%0t", tx_if.tx_data, $time);
               end
            end
         end
      endcase
   endtask

   task automatic compare_all();
      logic e_sbtx;
      e_sbtx = (m_phase == P_DISC) ? 1'b0 : (m_bits.size() != 0 ? m_bits[0] : 1'b1);
      check_val("sbtx", 32'(sbtx), 32'(e_sbtx));
      check_val("disconnected_s", 32'(disconnected_s), 32'(m_phase == P_DISC));
      check_val("connected", 32'(connected), 32'(m_phase == P_LINK));
      check_val("tx_busy", 32'(tx_busy), 32'(m_bits.size() != 0));
      check_val("tx_ready", 32'(tx_if.tx_ready), 32'(m_phase == P_LINK && m_bits.size() == 0));
   endtask

   task automatic cycle();
      @(posedge sb_clk);
      model_step();
      @(negedge sb_clk);
      compare_all();
   endtask

   task automatic connect_up();
      sbrx = 1'b1;
      for (int i = 0; i < 300 && !connected; i++) cycle();
      check_val("connect_up", 32'(connected), 32'd1);
   endtask

   initial begin
      int          low;
      int          rdy_low;
      int          burst;
      logic [7:0]  b1, b2;
      logic [10:0] v;
      logic        want[$];

      rst               = 1'b0;
      enable            = 1'b1;
      disconnect_req    = 1'b0;
      sbrx              = 1'b0;
      tx_if.tx_valid    = 1'b0;
      tx_if.tx_data     = 8'h00;
      model_reset();
      repeat (3) cycle();

      // Release reset: sbtx low for exactly TDX cycles, then CONNECTING.
      rst = 1'b1;
      #1 compare_all();
      low = (sbtx === 1'b0) ? 1 : 0;
      for (int i = 0; i < 200; i++) begin
         cycle();
         if (sbtx !== 1'b0) break;
         low++;
      end
      check_val("tdisc_low_after_reset", 32'(low), 32'(TDX));
      check_val("disc_s_after_low", 32'(disconnected_s), 32'd0);

      // A broken run of 24 ones does not connect; a full run of 25 does.
      sbrx = 1'b1;
      repeat (TCR-1) cycle();
      sbrx = 1'b0;
      cycle();
      check_val("no_conn_short_run", 32'(connected), 32'd0);
      sbrx = 1'b1;
      repeat (TCR-1) cycle();
      check_val("no_conn_24", 32'(connected), 32'd0);
      cycle();
      check_val("conn_after_25", 32'(connected), 32'd1);

      // Single frame 0xA5 followed by idle high.
      tx_if.tx_valid = 1'b1;
      tx_if.tx_data  = 8'hA5;
      cycle();
      tx_if.tx_valid = 1'b0;
      v       = frame_vec(8'hA5);
      rdy_low = 0;
      for (int k = 0; k <= FLEN; k++) begin
         if (k > 0) cycle();
         check_val("a5_bit", 32'(sbtx), (k < FLEN) ? 32'(v[k]) : 32'd1);
         if (tx_if.tx_ready === 1'b0) rdy_low++;
      end
      check_val("a5_ready_low", 32'(rdy_low), 32'(FLEN));

      // sbrx low for TDR-1 keeps the link; TDR drops it.
      sbrx = 1'b0;
      repeat (TDR-1) cycle();
      check_val("lo_13_connected", 32'(connected), 32'd1);
      sbrx = 1'b1;
      cycle();
      sbrx = 1'b0;
      repeat (TDR) cycle();
      check_val("lo_14_disc", 32'(disconnected_s), 32'd1);
      check_val("lo_14_sbtx", 32'(sbtx), 32'd0);

      // disconnect_req during data bit 3 aborts the frame.
      connect_up();
      b1 = 8'($urandom);
      tx_if.tx_valid = 1'b1;
      tx_if.tx_data  = b1;
      cycle();
      tx_if.tx_valid = 1'b0;
      repeat (4) cycle();
      check_val("abort_d3_on_line", 32'(sbtx), 32'(b1[3]));
      disconnect_req = 1'b1;
      cycle();
      disconnect_req = 1'b0;
      check_val("abort_sbtx", 32'(sbtx), 32'd0);
      check_val("abort_busy", 32'(tx_busy), 32'd0);
      low = 1;
      for (int i = 0; i < 200; i++) begin
         cycle();
         if (sbtx !== 1'b0) break;
         low++;
      end
      check_val("tdisc_low_after_abort", 32'(low), 32'(TDX));

      // Back-to-back bytes with valid held: one idle cycle between frames.
      connect_up();
      b1 = 8'($urandom);
      b2 = 8'($urandom);
      v  = frame_vec(b1);
      for (int i = 0; i < FLEN; i++) want.push_back(v[i]);
      want.push_back(1'b1);
      v = frame_vec(b2);
      for (int i = 0; i < FLEN; i++) want.push_back(v[i]);
      want.push_back(1'b1);
      tx_if.tx_valid = 1'b1;
      tx_if.tx_data  = b1;
      for (int k = 0; k < 2*FLEN+2; k++) begin
         cycle();
         if (k == 0) tx_if.tx_data = b2;
         if (k == FLEN+1) tx_if.tx_valid = 1'b0;
         check_val("b2b_bit", 32'(sbtx), 32'(want[k]));
      end

      // Randomized traffic, link events and mid-run resets.
      burst = 0;
      for (int c = 0; c < 3000; c++) begin
         if (c == 1000 || c == 2200) begin
            rst = 1'b0;
            #1;
            model_reset();
            compare_all();
            cycle();
            cycle();
            rst = 1'b1;
         end
         enable         = ($urandom_range(0, 149) != 0);
         disconnect_req = ($urandom_range(0, 299) == 0);
         tx_if.tx_valid = $urandom_range(0, 1) == 1;
         tx_if.tx_data  = 8'($urandom);
         if (burst > 0) begin
            sbrx = 1'b0;
            burst--;
         end else if ($urandom_range(0, 39) == 0) begin
            sbrx  = 1'b0;
            burst = $urandom_range(0, 17);
         end else begin
            sbrx = 1'b1;
         end
         cycle();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
